// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU opcodes and the multiply sequencer state encoding.
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_NE  = 4'b1001;
  localparam logic [3:0] ALU_GT  = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1100;
  localparam logic [3:0] ALU_SRA = 4'b1110;
  localparam logic [3:0] ALU_SRL = 4'b1111;

  typedef enum logic [2:0] {IDLE, ADD, SHL, SHR, DONE} mul_state_t;
endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response channel between the core and the iterative multiplier.
interface alu_mul_seq_if #(parameter int DATA_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_result;
  logic                  busy;

  modport master (output req_valid, op_a, op_b, resp_ready,
                  input  req_ready, resp_valid, resp_result, busy);
  modport slave  (input  req_valid, op_a, op_b, resp_ready,
                  output req_ready, resp_valid, resp_result, busy);
endinterface

// File: rtl/alu_mul_seq_alu.sv
// Combinational execute-stage ALU; the multiplier only exercises ADD/SLL/SRL.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [OPCODE_LENGTH-1:0] i_operation,
  input  logic [DATA_WIDTH-1:0]    i_src_a,
  input  logic [DATA_WIDTH-1:0]    i_src_b,
  output logic [DATA_WIDTH-1:0]    o_result
);
  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_src_b[SHW-1:0];

  always_comb begin
    o_result = '0;
    case (i_operation)
      ALU_AND: o_result = i_src_a & i_src_b;
      ALU_OR:  o_result = i_src_a | i_src_b;
      ALU_ADD: o_result = i_src_a + i_src_b;
      ALU_XOR: o_result = i_src_a ^ i_src_b;
      ALU_SUB: o_result = i_src_a - i_src_b;
      ALU_SLL: o_result = i_src_a << w_shamt;
      ALU_EQ:  o_result = {{(DATA_WIDTH-1){1'b0}}, i_src_a == i_src_b};
      ALU_NE:  o_result = {{(DATA_WIDTH-1){1'b0}}, i_src_a != i_src_b};
      ALU_GT:  o_result = {{(DATA_WIDTH-1){1'b0}}, $signed(i_src_a) > $signed(i_src_b)};
      ALU_SLT: o_result = {{(DATA_WIDTH-1){1'b0}}, $signed(i_src_a) < $signed(i_src_b)};
      ALU_SRA: o_result = DATA_WIDTH'($signed(i_src_a) >>> w_shamt);
      ALU_SRL: o_result = i_src_a >> w_shamt;
      default: o_result = '0;
    endcase
  end
endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier (low DATA_WIDTH bits of A*B) sequencing a private ALU.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_mul_seq_if.slave bus
);
  mul_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_prod;
  logic [5:0]            r_iter;

  logic [OPCODE_LENGTH-1:0] w_op;
  logic [DATA_WIDTH-1:0]    w_src_a;
  logic [DATA_WIDTH-1:0]    w_src_b;
  logic [DATA_WIDTH-1:0]    w_res;

  always_comb begin
    w_op    = OPCODE_LENGTH'(ALU_AND);
    w_src_a = '0;
    w_src_b = '0;
    case (r_state)
      ADD: begin
        w_op    = OPCODE_LENGTH'(ALU_ADD);
        w_src_a = r_prod;
        w_src_b = r_mcand;
      end
      SHL: begin
        w_op    = OPCODE_LENGTH'(ALU_SLL);
        w_src_a = r_mcand;
        w_src_b = DATA_WIDTH'(1);
      end
      SHR: begin
        w_op    = OPCODE_LENGTH'(ALU_SRL);
        w_src_a = r_mplier;
        w_src_b = DATA_WIDTH'(1);
      end
      default: ;
    endcase
  end

  alu #(.DATA_WIDTH(DATA_WIDTH), .OPCODE_LENGTH(OPCODE_LENGTH)) u_alu (
    .i_operation (w_op),
    .i_src_a     (w_src_a),
    .i_src_b     (w_src_b),
    .o_result    (w_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_iter   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_mcand  <= bus.op_a;
          r_mplier <= bus.op_b;
          r_prod   <= '0;
          r_iter   <= '0;
          if (bus.op_b == '0)  r_state <= DONE;
          else if (bus.op_b[0]) r_state <= ADD;
          else                  r_state <= SHL;
        end
        ADD: begin
          r_prod  <= w_res;
          r_state <= SHL;
        end
        SHL: begin
          r_mcand <= w_res;
          r_state <= SHR;
        end
        SHR: begin
          r_mplier <= w_res;
          r_iter   <= r_iter + 6'd1;
          // the iteration cap bounds the loop even if the multiplier never drains
          if (w_res == '0 || r_iter == 6'd31) r_state <= DONE;
          else if (w_res[0])                  r_state <= ADD;
          else                                r_state <= SHL;
        end
        DONE: if (bus.resp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.resp_valid  = (r_state == DONE);
  assign bus.resp_result = (r_state == DONE) ? r_prod : '0;
  assign bus.busy        = (r_state == ADD) || (r_state == SHL) || (r_state == SHR);
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed table, handshake/reset corner sequences and random products for alu_mul_seq.
module tb_alu_mul_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_mul_seq_if #(.DATA_WIDTH(32)) bus ();

  alu_mul_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          done;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference timing: two ALU steps per multiplier bit up to the top set bit, plus one add per set bit
  function automatic int model_done(input logic [31:0] b);
    int k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return 2 * k + $countones(b) + 1;
  endfunction

  function automatic logic [31:0] model_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = 64'(a) * 64'(b);
    return full[31:0];
  endfunction

  // called one step after a rising edge while the unit is idle; returns in cycle 1
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.op_a      = a;
    bus.op_b      = b;
    bus.req_valid = 1'b1;
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_done);
    int cyc = 1;
    bit busy_bad = 1'b0;
    while (bus.resp_valid !== 1'b1 && cyc <= 120) begin
      if (bus.busy !== (cyc < exp_done)) busy_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_done_cycle"}, 64'(cyc), 64'(exp_done));
    check({name, "_busy_profile"}, 64'(busy_bad), 64'd0);
    check({name, "_busy_in_done"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic handshake(input string name);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({name, "_idle_ready"}, 64'(bus.req_ready), 64'd1);
    check({name, "_idle_valid"}, 64'(bus.resp_valid), 64'd0);
  endtask

  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int done);
    start_op(a, b);
    wait_done(name, done);
    check({name, "_result"}, 64'(bus.resp_result), 64'(r));
    handshake(name);
  endtask

  initial begin
    vec_t tbl[5];
    bit   bad;

    tbl[0] = '{32'd6,        32'd7,        32'd42,       10};
    tbl[1] = '{32'h12345678, 32'd0,        32'd0,        1};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 97};
    tbl[3] = '{32'h00010000, 32'h00010000, 32'd0,        36};
    tbl[4] = '{32'd1,        32'h80000000, 32'h80000000, 66};

    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_result", 64'(bus.resp_result), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);

    // early resp_ready must not disturb an idle or busy unit
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("early_ready_idle", 64'(bus.req_ready), 64'd1);

    for (int i = 0; i < 5; i++)
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].done);

    // response held through backpressure while a new request waits
    start_op(32'd3, 32'd5);
    wait_done("stall", 9);
    bus.req_valid = 1'b1;
    bus.op_a      = 32'd2;
    bus.op_b      = 32'd3;
    bad = 1'b0;
    repeat (5) begin
      if (bus.resp_valid !== 1'b1 || bus.resp_result !== 32'd15 || bus.req_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("stall_hold_stable", 64'(bad), 64'd0);
    check("stall_result", 64'(bus.resp_result), 64'd15);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("stall_back_idle", 64'(bus.req_ready), 64'd1);
    check("stall_valid_low", 64'(bus.resp_valid), 64'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("stall_next_accept", 64'(bus.busy), 64'd1);
    wait_done("stall_next", model_done(32'd3));
    check("stall_next_result", 64'(bus.resp_result), 64'd6);
    handshake("stall_next");

    // reset in the middle of a long operation
    start_op(32'd100, 32'h80000000);
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_req_ready", 64'(bus.req_ready), 64'd1);
    check("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("abort_resp_result", 64'(bus.resp_result), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    bad = 1'b0;
    repeat (100) begin
      if (bus.resp_valid !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_response", 64'(bad), 64'd0);

    // reset while a finished product is waiting
    start_op(32'd9, 32'd9);
    wait_done("abort_done", model_done(32'd9));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_done_valid", 64'(bus.resp_valid), 64'd0);
    check("abort_done_ready", 64'(bus.req_ready), 64'd1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = $urandom_range(0, 255);
        2:       b = 32'd1 << $urandom_range(0, 31);
        default: b = $urandom & $urandom;
      endcase
      do_op($sformatf("rnd%0d", i), a, b, model_prod(a, b), model_done(b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply sequencer that computes the low 32 bits of A×B (RV32M `MUL` semantics, identical for signed and unsigned operands) by driving a private instance of the combinational `alu` through a shift-and-add loop. It sits beside the execute stage as an iterative functional unit. The core hands it operands over a valid/ready request channel and collects the product over a valid/ready response channel. Only existing ALU operations are used: ADD, SLLI and SRLI.

## Interface
- `DATA_WIDTH`, 32: operand/result width.
- `OPCODE_LENGTH`, 4: ALU operation code width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  operands valid.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `op_a`  in  DATA_WIDTH  multiplicand; sampled on accept.
- `op_b`  in  DATA_WIDTH  multiplier; sampled on accept.
- `resp_valid`  out  1  product valid; high only in DONE.
- `resp_ready`  in  1  consumer takes product.
- `resp_result`  out  DATA_WIDTH  product, low DATA_WIDTH bits.
- `busy`  out  1  high in ADD/SHL/SHR.

## Operation
- Registers:
  - `mcand`: multiplicand, shifted left.
  - `mplier`: multiplier, shifted right.
  - `prod`: accumulator.
  - `state`.
  - `iter`: 6-bit iteration counter.
- States: IDLE, ADD, SHL, SHR, DONE.
- IDLE: `req_ready`=1. On `req_valid`:
  - Load `mcand`=op_a, `mplier`=op_b, `prod`=0, `iter`=0.
  - Next state is DONE if op_b==0, else ADD if op_b[0], else SHL.
- ADD: ALU Operation=0010, SrcA=`prod`, SrcB=`mcand`. `prod`←ALUResult (wraps mod 2^32). Next state is SHL.
- SHL: ALU Operation=0111, SrcA=`mcand`, SrcB=1. `mcand`←ALUResult. Next state is SHR.
- SHR: ALU Operation=1111, SrcA=`mplier`, SrcB=1. `mplier`←ALUResult; `iter`←`iter`+1.
  - Next state is DONE if ALUResult==0 or `iter`==31.
  - Otherwise ADD if ALUResult[0], else SHL.
- DONE: `resp_valid`=1, `resp_result`=`prod`.
  - Both are held stable until `resp_ready`; then next state is IDLE.
  - `req_valid` is ignored in DONE.
- IDLE drives ALU Operation=0000 with SrcA=SrcB=0. The ALU result is not captured there.
- Overflow bits beyond DATA_WIDTH are discarded silently. There is no overflow flag.
- The `iter` guard makes 32 iterations a hard upper bound.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `state`=IDLE; `mcand`, `mplier`, `prod` and `iter` are cleared.
  - From the next cycle: `req_ready`=1, `resp_valid`=0, `resp_result`=0, `busy`=0.
- Reset mid-operation, including in DONE: the operation is aborted and no response is produced.
- Cycle numbering: cycle 0 is the accept edge. Cycle 1 is the first non-IDLE cycle.
- Let k = index of the highest set bit of op_b, plus 1, and p = popcount(op_b).
  - Busy cycles = 2k + p.
  - DONE is entered in cycle 2k+p+1.
  - For op_b==0, DONE is entered in cycle 1.
- Worst case (op_b=0xFFFFFFFF): 96 busy cycles, DONE in cycle 97.
- A response handshake in cycle n returns the unit to IDLE in cycle n+1. The earliest next accept is cycle n+1; no back-to-back accept in DONE.
- `resp_ready` high before DONE has no effect.
- All outputs are decoded from registered state plus `prod`. There is no combinational path from `req_valid`/`resp_ready` to any output.

## Structure
- Package `alu_pkg`:
  - ALU op constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_XOR=0101, ALU_SUB=0110, ALU_SLL=0111, ALU_EQ=1000, ALU_NE=1001, ALU_GT=1010, ALU_SLT=1100, ALU_SRA=1110, ALU_SRL=1111.
  - `mul_state_t` enum.
- One sub-module: `alu`, instantiated once with DATA_WIDTH/OPCODE_LENGTH passed through.
- The sequencer muxes SrcA/SrcB/Operation per state and captures ALUResult into the target register.

## Test plan
- op_a=6, op_b=7 → resp_result=42. DONE in cycle 10 (k=3, p=3), `busy` high in cycles 1–9.
- op_a=0x12345678, op_b=0 → resp_result=0, `resp_valid` in cycle 1, no busy cycles.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → resp_result=0x00000001, DONE in cycle 97.
- op_a=0x00010000, op_b=0x00010000 → resp_result=0 (wrap), DONE in cycle 36 (k=17, p=1).
- op_a=3, op_b=5 with `resp_ready` low for 5 cycles in DONE:
  - `resp_valid`=1 and resp_result=15 are held stable; `req_ready`=0 while `req_valid` is held high.
  - After the handshake, the next request is accepted one cycle later.
- op_a=100, op_b=0x80000000 with `rst_n` low at cycle 20 → from the next cycle IDLE, `req_ready`=1, `resp_valid`=0, resp_result=0, and no response is ever produced.
